// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte producers.
// Define UART_ARB_PKT_LOCK_EN to hold the grant on one requester until it sends a byte with req_last.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_byte,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_valid,
  output logic                       err_no_busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_ACK   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           state_r;
  logic [ID_W-1:0]  ptr_r;
  logic [CNT_W-1:0] ack_cnt_r;
  logic [7:0]       tx_byte_r;
  logic             tx_start_r;
  logic [ID_W-1:0]  grant_id_r;
  logic             grant_valid_r;
  logic             err_no_busy_r;

  logic [NUM_REQ-1:0] elig_s;
  logic               win_found_s;
  logic [ID_W-1:0]    win_id_s;
  logic [ID_W-1:0]    ptr_next_s;
  logic [7:0]         win_data_s;
  logic               accept_s;

`ifdef UART_ARB_PKT_LOCK_EN
  logic            lock_r;
  logic [ID_W-1:0] lock_id_r;
  logic            win_last_s;

  // Eligibility: while locked only the lock holder may win.
  always_comb begin
    if (lock_r) begin
      elig_s = req_valid & (NUM_REQ'(1'b1) << lock_id_r);
    end else begin
      elig_s = req_valid;
    end
  end

  // Packet-end flag of the current winner.
  always_comb begin
    win_last_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_id_s == ID_W'(k)) begin
        win_last_s = req_last[k];
      end else begin
        win_last_s = win_last_s;
      end
    end
  end
`else
  logic unused_last_s;
  assign unused_last_s = ^req_last;

  // Eligibility: every valid requester competes for each byte.
  always_comb begin
    elig_s = req_valid;
  end
`endif

  // Winner search: first eligible index at or above the pointer, else the lowest one below it.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found_s && elig_s[k] && (ID_W'(k) >= ptr_r)) begin
        win_found_s = 1'b1;
        win_id_s    = ID_W'(k);
      end else begin
        win_found_s = win_found_s;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found_s && elig_s[k]) begin
        win_found_s = 1'b1;
        win_id_s    = ID_W'(k);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Data mux for the winning requester.
  always_comb begin
    win_data_s = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_id_s == ID_W'(k)) begin
        win_data_s = req_data[8*k +: 8];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  // Pointer successor with wrap at NUM_REQ-1.
  always_comb begin
    if (win_id_s == ID_W'(NUM_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = win_id_s + 1'b1;
    end
  end

  // Reset gates ready so every output reads 0 while rst_n is low.
  always_comb begin
    accept_s = rst_n && (state_r == ST_IDLE) && !tx_busy && win_found_s;
    if (accept_s) begin
      req_ready = NUM_REQ'(1'b1) << win_id_s;
    end else begin
      req_ready = '0;
    end
  end

  // Arbitration FSM with registered launch, timeout and grant tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      ptr_r         <= '0;
      ack_cnt_r     <= '0;
      tx_byte_r     <= 8'h00;
      tx_start_r    <= 1'b0;
      grant_id_r    <= '0;
      grant_valid_r <= 1'b0;
      err_no_busy_r <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
      lock_r        <= 1'b0;
      lock_id_r     <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_start_r <= 1'b0;
          if (accept_s) begin
            state_r       <= ST_START;
            tx_start_r    <= 1'b1;
            tx_byte_r     <= win_data_s;
            grant_id_r    <= win_id_s;
            grant_valid_r <= 1'b1;
`ifdef UART_ARB_PKT_LOCK_EN
            if (win_last_s) begin
              lock_r <= 1'b0;
              ptr_r  <= ptr_next_s;
            end else begin
              lock_r    <= 1'b1;
              lock_id_r <= win_id_s;
            end
`else
            ptr_r <= ptr_next_s;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          tx_start_r <= 1'b0;
          ack_cnt_r  <= '0;
          state_r    <= ST_ACK;
        end
        ST_ACK: begin
          // Give up if uart_tx never acknowledges; the frame counts as done.
          if (tx_busy) begin
            state_r <= ST_DRAIN;
          end else if (ack_cnt_r == CNT_W'(ACK_TIMEOUT - 1)) begin
            err_no_busy_r <= 1'b1;
            grant_valid_r <= 1'b0;
            state_r       <= ST_IDLE;
          end else begin
            ack_cnt_r <= ack_cnt_r + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!tx_busy) begin
            grant_valid_r <= 1'b0;
            state_r       <= ST_IDLE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          tx_start_r    <= 1'b0;
          grant_valid_r <= 1'b0;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_byte     = tx_byte_r;
  assign tx_start    = tx_start_r;
  assign grant_id    = grant_id_r;
  assign grant_valid = grant_valid_r;
  assign err_no_busy = err_no_busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: uart_tx model, 104-clock serial receiver and byte scoreboard.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 3;
  localparam int ACK_TIMEOUT = 4;
  localparam int BIT_CLKS    = 104;
  localparam int FRAME_CLKS  = 1040;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_byte;
  logic                 tx_start;
  logic                 tx_busy;
  logic [1:0]           grant_id;
  logic                 grant_valid;
  logic                 err_no_busy;
  logic                 busy_force_en = 1'b0;
  logic                 busy_force_val = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb[$];
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];

  int         cyc = 0;
  bit         pend_acc = 1'b0;
  int         pend_id = 0;
  logic [7:0] pend_byte = 8'h00;
  int         acc_cyc = 0;
  logic [NUM_REQ-1:0] acc_ready = '0;
  int         n_acc = 0;
  int         n_starts = 0;
  int         max_ones = 0;
  int         blk_viol = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_id(grant_id), .grant_valid(grant_valid), .err_no_busy(err_no_busy)
  );

  always #5 clk = ~clk;

  // uart_tx model: 8N1 frame of 1040 clocks, busy from the clock after tx_start.
  logic        m_busy;
  logic [10:0] m_cnt;
  logic [9:0]  m_sh;
  logic        serial;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 11'd0;
      m_sh   <= 10'h3FF;
    end else if (!m_busy) begin
      if (tx_start && !busy_force_en) begin
        m_busy <= 1'b1;
        m_cnt  <= 11'd0;
        m_sh   <= {1'b1, tx_byte, 1'b0};
      end
    end else if (m_cnt == 11'(FRAME_CLKS - 1)) begin
      m_busy <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 11'd1;
      if ((m_cnt + 11'd1) % 11'(BIT_CLKS) == 11'd0) m_sh <= {1'b1, m_sh[9:1]};
    end
  end
  assign serial  = m_busy ? m_sh[0] : 1'b1;
  assign tx_busy = busy_force_en ? busy_force_val : m_busy;

  // Serial receiver sampling mid-bit at 104 clocks per bit.
  logic        rx_act, rx_done;
  logic [10:0] rx_cnt;
  logic [9:0]  rx_sh;
  logic [7:0]  rx_exp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_act  <= 1'b0;
      rx_done <= 1'b0;
      rx_cnt  <= 11'd0;
      rx_sh   <= 10'h000;
    end else begin
      rx_done <= 1'b0;
      if (!rx_act) begin
        if (!serial) begin
          rx_act <= 1'b1;
          rx_cnt <= 11'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + 11'd1;
        if (rx_cnt >= 11'd52 && (rx_cnt - 11'd52) % 11'(BIT_CLKS) == 11'd0) rx_sh <= {serial, rx_sh[9:1]};
        if (rx_cnt == 11'(52 + 9 * BIT_CLKS)) begin
          rx_act  <= 1'b0;
          rx_done <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rx_done) begin
      if (sb.size() == 0) begin
        check("rx_extra_byte", 32'(sb.size()), 32'd1);
      end else begin
        rx_exp = sb.pop_front();
        check("rx_byte", 32'(rx_sh[8:1]), 32'(rx_exp));
        check("rx_frame_bits", 32'({rx_sh[9], rx_sh[0]}), 32'd2);
      end
    end
  end

  task automatic drive_reqs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    if (q0.size() != 0) begin req_valid[0] = 1'b1; req_data[7:0]   = q0[0][7:0]; req_last[0] = q0[0][8]; end
    if (q1.size() != 0) begin req_valid[1] = 1'b1; req_data[15:8]  = q1[0][7:0]; req_last[1] = q1[0][8]; end
    if (q2.size() != 0) begin req_valid[2] = 1'b1; req_data[23:16] = q2[0][7:0]; req_last[2] = q2[0][8]; end
  endtask

  task automatic step();
    @(negedge clk);
    if (pend_acc) begin
      check("tx_start_after_accept", 32'(tx_start), 32'd1);
      check("grant_id", 32'(grant_id), 32'(pend_id));
      check("grant_valid", 32'(grant_valid), 32'd1);
      check("tx_byte", 32'(tx_byte), 32'(pend_byte));
      pend_acc = 1'b0;
    end
    if (tx_start) n_starts++;
    if ($countones(req_ready) > max_ones) max_ones = $countones(req_ready);
    if (busy_force_en && busy_force_val && (req_ready != '0 || tx_start)) blk_viol++;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid[k] && req_ready[k]) begin
        pend_acc  = 1'b1;
        pend_id   = k;
        pend_byte = req_data[8*k +: 8];
        acc_cyc   = cyc;
        acc_ready = req_ready;
        n_acc++;
        if (k == 0) void'(q0.pop_front());
        else if (k == 1) void'(q1.pop_front());
        else void'(q2.pop_front());
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    drive_reqs();
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && sb.size() == 0 &&
             !grant_valid && !rx_act) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    pend_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n0, s0, rel, n;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_err_no_busy", 32'(err_no_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester
    q1.push_back({1'b1, 8'h42});
    sb.push_back(8'h42);
    drive_reqs();
    n0 = n_acc; s0 = n_starts;
    step();
    check("single_accept_count", 32'(n_acc - n0), 32'd1);
    check("single_ready", 32'(acc_ready), 32'b010);
    step();
    step();
    check("single_start_one_cycle", 32'(tx_start), 32'd0);
    n = 0;
    while (grant_valid && n < 1200) begin step(); n++; end
    check("single_back_to_idle", 32'(cyc - acc_cyc), 32'd1043);
    wait_done(200, "single_done");
    check("single_start_count", 32'(n_starts - s0), 32'd1);

    // Round-robin from pointer 0
    do_reset();
    max_ones = 0; s0 = n_starts;
    q0.push_back({1'b1, 8'h41}); q0.push_back({1'b1, 8'h41});
    q1.push_back({1'b1, 8'h42});
    q2.push_back({1'b1, 8'h43});
    sb.push_back(8'h41); sb.push_back(8'h42); sb.push_back(8'h43); sb.push_back(8'h41);
    drive_reqs();
    wait_done(5000, "rr_done");
    check("rr_start_count", 32'(n_starts - s0), 32'd4);
    check("rr_ready_onehot", 32'(max_ones), 32'd1);

    // Busy blocking
    busy_force_en = 1'b1; busy_force_val = 1'b1;
    q0.push_back({1'b1, 8'h77});
    drive_reqs();
    blk_viol = 0; n0 = n_acc;
    repeat (20) step();
    check("busy_no_ready_no_start", 32'(blk_viol), 32'd0);
    check("busy_no_accept", 32'(n_acc - n0), 32'd0);
    busy_force_en = 1'b0;
    sb.push_back(8'h77);
    rel = cyc;
    step();
    check("busy_release_accept", 32'(n_acc - n0), 32'd1);
    check("busy_release_cycle", 32'(acc_cyc), 32'(rel));
    wait_done(1200, "busy_done");

    // ACK timeout with tx_busy stuck low
    busy_force_en = 1'b1; busy_force_val = 1'b0;
    q1.push_back({1'b1, 8'h55});
    drive_reqs();
    s0 = n_starts;
    step();
    while (cyc < acc_cyc + 5) step();
    check("timeout_err_early", 32'(err_no_busy), 32'd0);
    step();
    check("timeout_err_set", 32'(err_no_busy), 32'd1);
    check("timeout_grant_cleared", 32'(grant_valid), 32'd0);
    check("timeout_start_count", 32'(n_starts - s0), 32'd1);
    busy_force_en = 1'b0;
    q2.push_back({1'b1, 8'h66});
    sb.push_back(8'h66);
    drive_reqs();
    rel = cyc;
    step();
    check("timeout_back_in_idle", 32'(acc_cyc), 32'(rel));
    wait_done(1200, "timeout_done");
    check("timeout_err_sticky", 32'(err_no_busy), 32'd1);

    // Mid-frame reset during DRAIN
    q0.push_back({1'b1, 8'h31});
    drive_reqs();
    repeat (300) step();
    check("midrst_pre_grant_valid", 32'(grant_valid), 32'd1);
    rst_n = 1'b0;
    pend_acc = 1'b0;
    #2;
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    check("midrst_tx_byte", 32'(tx_byte), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
    check("midrst_grant_valid", 32'(grant_valid), 32'd0);
    check("midrst_err", 32'(err_no_busy), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    q0.push_back({1'b1, 8'hA0});
    q2.push_back({1'b1, 8'h99});
    sb.push_back(8'hA0); sb.push_back(8'h99);
    drive_reqs();
    wait_done(2500, "midrst_done");

    // Packet lock: requester 0 sends "AB", requester 1 offers 0x5A
    do_reset();
    q0.push_back({1'b0, 8'h41}); q0.push_back({1'b1, 8'h42});
    q1.push_back({1'b1, 8'h5A});
`ifdef UART_ARB_PKT_LOCK_EN
    sb.push_back(8'h41); sb.push_back(8'h42); sb.push_back(8'h5A);
`else
    sb.push_back(8'h41); sb.push_back(8'h5A); sb.push_back(8'h42);
`endif
    drive_reqs();
    wait_done(4000, "pkt_done");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
